maxpool_ctrl: RTL and testbench
===============================

# maxpool_ctrl

Sequencer for the BNN binary max-pooling accumulator (the pool unit). It scans a binary feature map held in a 1-bit-wide on-chip memory, one K×K window at a time, and streams each window's bits into the pool unit with per-channel OR-accumulate strobes. It then reads and clears the pool unit and hands the CH-bit pooled vector downstream through a valid/ready handshake. It sits between the conv/binarize stage's feature-map buffer and the FC layer input.

## Interface
- IMG_W, 8, feature-map width in pixels; must be a multiple of K
- IMG_H, 8, feature-map height in pixels; must be a multiple of K
- CH, 5, channels per pixel; must equal the pool unit's WL; CH ≤ 128
- K, 2, window size and stride
- iCLK  in  1  clock. One clock domain.
- iRSTn  in  1  reset. Synchronous and active-low.
- iStart  in  1  single-cycle start request; sampled only in IDLE
- oMemADDR  out  AW  feature-map bit address. AW = clog2(IMG_H·IMG_W·CH), which is 9 at the defaults.
- iMemDATA  in  1  memory read data; valid in the cycle after its address
- oPoolWE  out  1  pool-unit write enable (OR-accumulate)
- oPoolRE  out  1  pool-unit read enable (read and clear)
- oPoolADDR  out  7  pool-unit channel index
- oPoolBIT  out  1  pool-unit data bit
- iPoolDATA  in  CH  pool-unit output; valid while oPoolRE is high
- oDATA  out  CH  pooled vector, registered
- oValid  out  1  oDATA valid
- iReady  in  1  downstream accept
- oBusy  out  1  high from the first FETCH cycle until oDone
- oDone  out  1  one-cycle pulse after the last vector is accepted

## Operation
- Memory bit address = (row·IMG_W + col)·CH + ch.
- Output pixels are visited in raster order: py = 0..IMG_H/K−1, then px = 0..IMG_W/K−1. Total outputs = (IMG_H/K)·(IMG_W/K), which is 16 at the defaults.
- Within each window the loop order is ky, then kx, then ch, with ch innermost. N = K·K·CH address cycles, which is 20 at the defaults.
- FSM states:
  - IDLE: on iStart go to FETCH. The window counters are already zero.
  - FETCH: issue one address per cycle for N cycles.
    - Each address's data is written to the pool unit one cycle later: oPoolWE=1, oPoolADDR=ch of that address (delayed 1 cycle), oPoolBIT=iMemDATA.
    - After the Nth address, go to LAST, which performs the final write.
  - LAST: go to READ.
  - READ: oPoolRE=1, oPoolBIT=0, oPoolADDR=0. Capture iPoolDATA into oDATA. The pool unit reloads to all-zero on this edge. Go to OUT.
  - OUT: oValid=1 and oDATA is held. When iValid·iReady (oValid & iReady) is seen:
    - if more pixels remain, advance the pixel counters and go to FETCH;
    - otherwise go to DONE.
  - DONE: oDone=1 for one cycle, then go to IDLE.
- oPoolWE and oPoolRE are never high together.
- Pool strobes are only issued for addresses fetched in the current window.
- iStart outside IDLE is ignored.
- Reset (iRSTn low at a clock edge) applies from any state, mid-window included. The FSM goes to IDLE and all counters clear.
  - All outputs read 0 after that edge: oDATA, oMemADDR, oPoolADDR, oPoolBIT, and every strobe.
  - The pool unit shares the reset net and clears with it.

## Timing
- Cycle numbering: iStart is sampled in cycle 0.
  - Address cycles: 1..N.
  - Write cycles: 2..N+1.
  - READ: cycle N+2.
  - oValid: from cycle N+3, which is cycle 23 at the defaults.
- Per-window latency from FETCH entry to oValid is N+2 cycles.
- If the accept happens in cycle a, the next window's first address is in cycle a+1.
- Backpressure: while oValid=1 and iReady=0, oDATA, oMemADDR and all pool strobes are frozen, and no memory reads are issued.
- oDone is high in the cycle after the final accept. oBusy falls in that same cycle.
- Counter wrap: kx→ky at K, ch→kx at CH, px→py at IMG_W/K.
  - The last window's address is (IMG_H−1, IMG_W−1, CH−1).
  - No out-of-range address is ever driven.

## Structure
- Package bnn_pkg holds:
  - the FSM state enum (IDLE, FETCH, LAST, READ, OUT, DONE);
  - the default dimension constants;
  - the AW derivation function.
- Sub-module maxpool_addr_gen holds the nested ky/kx/ch/px/py counters. It computes the memory address and flags last-in-window and last-pixel. It advances on an enable from the FSM.
- The FSM, the 1-cycle write-alignment register and the oDATA register stay in maxpool_ctrl.

## Test plan
- All-zero map, iReady=1 → 16 vectors of 5'b00000, then an oDone pulse. First oValid in cycle 23.
- Single bit set at row 3, col 5, ch 2 → vector index 6 (py=1, px=2) = 5'b00100. All other vectors are 0.
- All-ones map → all 16 vectors 5'b11111. oPoolWE is high 20 cycles per window and oPoolRE 1 cycle per window.
- iReady held low 10 cycles on vector 0 → oDATA and oMemADDR are stable and there are no pool strobes. Next address appears the cycle after the accept.
- iRSTn low in cycle 12 of window 3:
  - all outputs are 0 next cycle and the FSM is in IDLE;
  - after restart, vector 0 is correct, with no stale OR bits.
- iStart pulsed repeatedly while busy → ignored. Exactly 16 vectors and one oDone.

Source files
------------

// File: rtl/bnn_pkg.sv
// BNN max-pool shared types: FSM states, default geometry,
// and width helpers for the pool sequencer.
package bnn_pkg;

  localparam int IMG_W_D = 8;
  localparam int IMG_H_D = 8;
  localparam int CH_D    = 5;
  localparam int K_D     = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LAST,
    READ,
    OUT,
    DONE
  } state_t;

  function automatic int calcAW(int h, int w, int c);
    return $clog2(h * w * c);
  endfunction

  function automatic int cntW(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/maxpool_ctrl_if.sv
// Downstream pooled-vector stream with valid/ready handshake.
// master drives data/valid, slave returns ready.
interface maxpool_ctrl_if #(
  parameter int CH = 5
);
  logic [CH-1:0] oDATA;
  logic          oValid;
  logic          iReady;

  modport master (
    output oDATA,
    output oValid,
    input  iReady
  );

  modport slave (
    input  oDATA,
    input  oValid,
    output iReady
  );
endinterface

// File: rtl/maxpool_addr_gen.sv
// Nested ky/kx/ch window counters and px/py pixel counters
// producing the feature-map bit address.
module maxpool_addr_gen
  import bnn_pkg::*;
#(
  parameter int IMG_W = IMG_W_D,
  parameter int IMG_H = IMG_H_D,
  parameter int CH    = CH_D,
  parameter int K     = K_D,
  parameter int AW    = 9
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          advWin,
  input  logic          advPix,
  output logic [AW-1:0] addr,
  output logic [6:0]    chan,
  output logic          lastInWin,
  output logic          lastPix
);

  localparam int PW  = IMG_W / K;
  localparam int PH  = IMG_H / K;
  localparam int CHW = cntW(CH);
  localparam int KW  = cntW(K);
  localparam int PXW = cntW(PW);
  localparam int PYW = cntW(PH);

  logic [CHW-1:0] ch;
  logic [KW-1:0]  kx;
  logic [KW-1:0]  ky;
  logic [PXW-1:0] px;
  logic [PYW-1:0] py;

  logic lastCh;
  logic lastKx;
  logic lastKy;
  logic lastPx;
  logic lastPy;

  assign lastCh = (ch == CHW'(CH - 1));
  assign lastKx = (kx == KW'(K - 1));
  assign lastKy = (ky == KW'(K - 1));
  assign lastPx = (px == PXW'(PW - 1));
  assign lastPy = (py == PYW'(PH - 1));

  assign lastInWin = lastCh & lastKx & lastKy;
  assign lastPix   = lastPx & lastPy;

  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      ch <= '0;
      kx <= '0;
      ky <= '0;
      px <= '0;
      py <= '0;
    end else begin
      if (advWin) begin
        if (lastCh) begin
          ch <= '0;
          if (lastKx) begin
            kx <= '0;
            ky <= lastKy ? '0 : ky + 1'b1;
          end else begin
            kx <= kx + 1'b1;
          end
        end else begin
          ch <= ch + 1'b1;
        end
      end
      if (advPix) begin
        if (lastPx) begin
          px <= '0;
          py <= lastPy ? '0 : py + 1'b1;
        end else begin
          px <= px + 1'b1;
        end
      end
    end
  end

  logic [AW-1:0] row;
  logic [AW-1:0] col;

  assign row  = AW'(py) * AW'(K) + AW'(ky);
  assign col  = AW'(px) * AW'(K) + AW'(kx);
  assign addr = (row * AW'(IMG_W) + col) * AW'(CH) + AW'(ch);
  assign chan = 7'(ch);

endmodule

// File: rtl/maxpool_ctrl.sv
// Binary max-pool sequencer: streams each KxK window into the
// pool unit, reads/clears it and hands the vector downstream.
module maxpool_ctrl
  import bnn_pkg::*;
#(
  parameter  int IMG_W = IMG_W_D,
  parameter  int IMG_H = IMG_H_D,
  parameter  int CH    = CH_D,
  parameter  int K     = K_D,
  localparam int AW    = calcAW(IMG_H, IMG_W, CH)
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iStart,
  output logic [AW-1:0] oMemADDR,
  input  logic          iMemDATA,
  output logic          oPoolWE,
  output logic          oPoolRE,
  output logic [6:0]    oPoolADDR,
  output logic          oPoolBIT,
  input  logic [CH-1:0] iPoolDATA,
  output logic          oBusy,
  output logic          oDone,
  maxpool_ctrl_if.master dn
);

  state_t state;
  state_t nxt;

  logic advWin;
  logic advPix;
  logic rdPool;
  logic valid;
  logic lastInWin;
  logic lastPix;
  logic [6:0] chan;

  maxpool_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CH    (CH),
    .K     (K),
    .AW    (AW)
  ) u_addr (
    .iCLK      (iCLK),
    .iRSTn     (iRSTn),
    .advWin    (advWin),
    .advPix    (advPix),
    .addr      (oMemADDR),
    .chan      (chan),
    .lastInWin (lastInWin),
    .lastPix   (lastPix)
  );

  always_ff @(posedge iCLK) begin
    if (!iRSTn) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt    = state;
    advWin = 1'b0;
    advPix = 1'b0;
    rdPool = 1'b0;
    valid  = 1'b0;
    oBusy  = 1'b0;
    oDone  = 1'b0;
    unique case (state)
      IDLE: if (iStart) nxt = FETCH;
      FETCH: begin
        oBusy  = 1'b1;
        advWin = 1'b1;
        if (lastInWin) nxt = LAST;
      end
      LAST: begin
        oBusy = 1'b1;
        nxt   = READ;
      end
      READ: begin
        oBusy  = 1'b1;
        rdPool = 1'b1;
        nxt    = OUT;
      end
      OUT: begin
        oBusy = 1'b1;
        valid = 1'b1;
        if (dn.iReady) begin
          advPix = 1'b1;
          nxt    = lastPix ? DONE : FETCH;
        end
      end
      DONE: begin
        oDone = 1'b1;
        nxt   = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // memory data lags its address by one cycle, so the
  // channel index and write strobe follow it
  logic       wrValid;
  logic [6:0] wrCh;

  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      wrValid  <= 1'b0;
      wrCh     <= '0;
      dn.oDATA <= '0;
    end else begin
      wrValid <= advWin;
      wrCh    <= chan;
      if (rdPool) dn.oDATA <= iPoolDATA;
    end
  end

  assign oPoolWE   = wrValid;
  assign oPoolRE   = rdPool;
  assign oPoolADDR = wrValid ? wrCh : 7'd0;
  assign oPoolBIT  = wrValid & iMemDATA;
  assign dn.oValid = valid;

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Directed bench for maxpool_ctrl with memory and pool-unit
// models; checks vectors, timing, backpressure and reset.
module tb_maxpool_ctrl;
  import bnn_pkg::*;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int C    = 5;
  localparam int KK   = 2;
  localparam int AW   = 9;
  localparam int NPIX = 16;
  localparam int MEMN = 320;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          memData = 1'b0;
  logic [AW-1:0] memAddr;
  logic          poolWE;
  logic          poolRE;
  logic [6:0]    poolAddr;
  logic          poolBIT;
  logic [C-1:0]  pool;
  logic          busy;
  logic          done;

  maxpool_ctrl_if #(.CH(C)) dn ();

  maxpool_ctrl #(
    .IMG_W (W),
    .IMG_H (H),
    .CH    (C),
    .K     (KK)
  ) dut (
    .iCLK      (clk),
    .iRSTn     (rstn),
    .iStart    (start),
    .oMemADDR  (memAddr),
    .iMemDATA  (memData),
    .oPoolWE   (poolWE),
    .oPoolRE   (poolRE),
    .oPoolADDR (poolAddr),
    .oPoolBIT  (poolBIT),
    .iPoolDATA (pool),
    .oBusy     (busy),
    .oDone     (done),
    .dn        (dn)
  );

  always #5 clk = ~clk;

  logic mem [MEMN];

  always @(posedge clk)
    memData <= (memAddr < AW'(MEMN)) ? mem[memAddr] : 1'b0;

  always @(posedge clk) begin
    if (!rstn) pool <= '0;
    else if (poolRE) pool <= '0;
    else if (poolWE && poolAddr < 7'(C))
      pool[poolAddr[2:0]] <= pool[poolAddr[2:0]] | poolBIT;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nTests = 0;
  int nFail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int weCnt = 0, reCnt = 0, bothCnt = 0, doneCnt = 0;
  int nVec = 0, badAddr = 0, holdStrobe = 0, holdMove = 0;
  logic [C-1:0]  vec [256];
  bit            holdOn = 1'b0;
  logic [C-1:0]  heldData = '0;
  logic [AW-1:0] heldAddr = '0;

  always @(negedge clk) begin
    if (poolWE) weCnt++;
    if (poolRE) reCnt++;
    if (poolWE && poolRE) bothCnt++;
    if (done) doneCnt++;
    if (memAddr >= AW'(MEMN)) badAddr++;
    if (dn.oValid && dn.iReady) begin
      if (nVec < 256) vec[nVec] = dn.oDATA;
      nVec++;
    end
    if (holdOn) begin
      if (poolWE || poolRE) holdStrobe++;
      if (dn.oDATA !== heldData || memAddr !== heldAddr) holdMove++;
    end
  end

  function automatic logic [C-1:0] expVec(int idx);
    logic [C-1:0] v = '0;
    int py = idx / (W / KK);
    int px = idx % (W / KK);
    for (int ky = 0; ky < KK; ky++)
      for (int kx = 0; kx < KK; kx++)
        for (int c = 0; c < C; c++)
          if (mem[((py*KK+ky)*W + px*KK+kx)*C + c]) v[c] = 1'b1;
    return v;
  endfunction

  task automatic setMap(input int mode);
    for (int i = 0; i < MEMN; i++) begin
      case (mode)
        1:       mem[i] = 1'b1;
        2:       mem[i] = (i == 147);
        4:       mem[i] = ((i * 7) % 11) < 2;
        default: mem[i] = 1'b0;
      endcase
    end
    if (mode == 3) begin
      mem[46] = 1'b1;
      mem[24] = 1'b1;
      for (int r = 0; r < 2; r++)
        for (int c = 6; c < 8; c++)
          for (int ch = 0; ch < C; ch++)
            mem[(r*W + c)*C + ch] = 1'b1;
    end
  endtask

  bit spamOn = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    start = spamOn && busy;
  endtask

  int vBase = 0;

  task automatic runFrame(input string tag, input int hold,
                          input bit spam);
    int we0 = weCnt;
    int re0 = reCnt;
    int bo0 = bothCnt;
    int dc0 = doneCnt;
    int ba0 = badAddr;
    int hs0;
    int hm0;
    int sc;
    int lat = -1;
    bit ok = 1'b0;
    vBase  = nVec;
    spamOn = 1'b0;
    @(posedge clk);
    #1;
    start     = 1'b1;
    sc        = cyc;
    dn.iReady = (hold == 0);
    spamOn    = spam;
    step();
    for (int i = 0; i < 200 && lat < 0; i++) begin
      if (dn.oValid) lat = cyc - sc;
      else step();
    end
    check({tag, "_lat"}, lat, 23);
    if (hold > 0) begin
      check({tag, "_held"}, dn.oDATA, 5'b11111);
      heldData = dn.oDATA;
      heldAddr = memAddr;
      hs0      = holdStrobe;
      hm0      = holdMove;
      holdOn   = 1'b1;
      repeat (hold) step();
      holdOn = 1'b0;
      check({tag, "_holdStrb"}, holdStrobe - hs0, 0);
      check({tag, "_holdMove"}, holdMove - hm0, 0);
      check({tag, "_holdValid"}, dn.oValid, 1'b1);
      dn.iReady = 1'b1;
      step();
      check({tag, "_nextAddr"}, memAddr, 10);
      check({tag, "_nextBusy"}, busy, 1'b1);
    end
    for (int i = 0; i < 1500 && !ok; i++) begin
      if (done) ok = 1'b1;
      else step();
    end
    spamOn = 1'b0;
    start  = 1'b0;
    check({tag, "_timeout"}, ok, 1'b1);
    check({tag, "_busyAtDone"}, busy, 1'b0);
    step();
    check({tag, "_nVec"}, nVec - vBase, NPIX);
    check({tag, "_done"}, doneCnt - dc0, 1);
    check({tag, "_we"}, weCnt - we0, NPIX * 20);
    check({tag, "_re"}, reCnt - re0, NPIX);
    check({tag, "_overlap"}, bothCnt - bo0, 0);
    check({tag, "_badAddr"}, badAddr - ba0, 0);
    for (int v = 0; v < NPIX; v++)
      check($sformatf("%s_vec%0d", tag, v), vec[vBase+v], expVec(v));
  endtask

  initial begin
    dn.iReady = 1'b0;
    setMap(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", dn.oValid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_addr", memAddr, 0);
    check("rst_data", dn.oDATA, 0);
    check("rst_we", poolWE, 1'b0);
    rstn = 1'b1;
    step();

    setMap(0);
    runFrame("zero", 0, 1'b0);
    for (int v = 0; v < NPIX; v++)
      check("zero_const", vec[vBase+v], 5'b00000);

    setMap(2);
    runFrame("single", 0, 1'b0);
    check("single_v6", vec[vBase+6], 5'b00100);
    check("single_v5", vec[vBase+5], 5'b00000);

    setMap(1);
    runFrame("ones", 0, 1'b0);
    for (int v = 0; v < NPIX; v++)
      check("ones_const", vec[vBase+v], 5'b11111);

    runFrame("bp", 10, 1'b0);

    begin
      bit reached = 1'b0;
      setMap(3);
      vBase     = nVec;
      dn.iReady = 1'b1;
      start     = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 500 && !reached; i++) begin
        if (nVec - vBase >= 3) reached = 1'b1;
        else step();
      end
      check("rsw_reach", reached, 1'b1);
      repeat (11) step();
      check("rsw_preData", dn.oDATA, 5'b10000);
      check("rsw_preBusy", busy, 1'b1);
      rstn = 1'b0;
      step();
      check("rsw_valid", dn.oValid, 1'b0);
      check("rsw_data", dn.oDATA, 0);
      check("rsw_addr", memAddr, 0);
      check("rsw_pAddr", poolAddr, 0);
      check("rsw_pBit", poolBIT, 1'b0);
      check("rsw_we", poolWE, 1'b0);
      check("rsw_re", poolRE, 1'b0);
      check("rsw_done", done, 1'b0);
      check("rsw_busy", busy, 1'b0);
      rstn = 1'b1;
      step();
      check("rsw_idle", busy, 1'b0);
    end
    runFrame("rst", 0, 1'b0);
    check("rst_v0", vec[vBase+0], 5'b00010);
    check("rst_v2", vec[vBase+2], 5'b10000);
    check("rst_v3", vec[vBase+3], 5'b11111);

    setMap(4);
    runFrame("spam", 0, 1'b1);
    repeat (5) step();
    check("spam_idle", busy, 1'b0);
    check("spam_noValid", dn.oValid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
